// File: rtl/de0_nano_pkg.sv
// Shared DE0-Nano AGC constants and elaboration-time helpers.
package de0_nano_pkg;

  localparam int unsigned CLK_HZ     = 51_200_000;
  localparam int unsigned AGC_CLK_HZ = 2_048_000;

  // Converts a millisecond interval into SIM_CLK cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // Bits needed to hold a counter value in 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// One board-input channel: polarity fix, two-flop synchroniser, debouncer,
// and a retriggerable one-shot selectable against a plain level output.
module input_debounce_ch
  import de0_nano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 3,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          PULSE_MODE      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_edge,
  output logic o_out,
  output logic o_change
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned PW = cnt_width(PULSE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LOAD = PW'(PULSE_CYCLES);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_edge;
  logic          r_change;
  logic [PW-1:0] r_pulse;
  logic          r_pulse_out;

  logic          w_sample;
  logic          w_differ;
  logic          w_flip;
  logic          w_rise;
  logic [PW-1:0] w_pulse_next;

  assign w_sample = i_raw ^ ACTIVE_LOW;
  assign w_differ = (r_sync[1] != r_stable);
  assign w_flip   = w_differ && (r_cnt == C_LAST);
  assign w_rise   = w_flip && !r_stable;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], w_sample};
    end
  end

  // Any agreeing sample restarts the window; the counter stops at C_LAST.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (!w_differ) begin
      r_cnt    <= '0;
    end else if (w_flip) begin
      r_stable <= ~r_stable;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge   <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_edge   <= w_rise;
      r_change <= w_flip;
    end
  end

  always_comb begin
    w_pulse_next = r_pulse;
    if (w_rise) begin
      w_pulse_next = P_LOAD;
    end else if (r_pulse != '0) begin
      w_pulse_next = r_pulse - PW'(1);
    end
  end

  // Output flop tracks the next counter value so it rises with the edge strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pulse     <= '0;
      r_pulse_out <= 1'b0;
    end else begin
      r_pulse     <= w_pulse_next;
      r_pulse_out <= (w_pulse_next != '0);
    end
  end

  assign o_level  = r_stable;
  assign o_edge   = r_edge;
  assign o_change = r_change;
  assign o_out    = PULSE_MODE ? r_pulse_out : r_stable;

endmodule

// File: rtl/de0_nano_input_conditioner.sv
// Conditioned front end for DE0-Nano keys and switches feeding fpga_agc:
// one debounce channel per pin plus a combined change strobe.
module de0_nano_input_conditioner
  import de0_nano_pkg::*;
#(
  parameter int unsigned    NCH             = 8,
  parameter int unsigned    DEBOUNCE_CYCLES = ms_to_cycles(20),
  parameter int unsigned    PULSE_CYCLES    = 16,
  parameter logic [NCH-1:0] ACTIVE_LOW      = {NCH{1'b1}},
  parameter logic [NCH-1:0] PULSE_MASK      = {NCH{1'b0}}
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic [NCH-1:0] RAW,
  output logic [NCH-1:0] LEVEL,
  output logic [NCH-1:0] EDGE,
  output logic [NCH-1:0] OUT,
  output logic           ANY_CHANGE
);

  logic [NCH-1:0] w_change;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    input_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW[gi]),
      .PULSE_MODE      (PULSE_MASK[gi])
    ) u_ch (
      .i_clk    (SIM_CLK),
      .i_rst    (SIM_RST),
      .i_raw    (RAW[gi]),
      .o_level  (LEVEL[gi]),
      .o_edge   (EDGE[gi]),
      .o_out    (OUT[gi]),
      .o_change (w_change[gi])
    );
  end

  // Per-channel change flags are registered, so this is a clean single strobe.
  assign ANY_CHANGE = |w_change;

endmodule

// File: tb/tb_de0_nano_input_conditioner.sv
// Randomised and directed check of the input conditioner against a
// sliding-window debounce model.
module tb_de0_nano_input_conditioner;

  localparam int unsigned NCH = 4;
  localparam int unsigned D   = 4;
  localparam int unsigned PC  = 3;
  localparam logic [3:0]  AL  = 4'b0001;
  localparam logic [3:0]  PM  = 4'b0001;

  logic       SIM_CLK;
  logic       SIM_RST;
  logic [3:0] RAW;
  logic [3:0] LEVEL;
  logic [3:0] EDGE;
  logic [3:0] OUT;
  logic       ANY_CHANGE;

  de0_nano_input_conditioner #(
    .NCH             (NCH),
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (PC),
    .ACTIVE_LOW      (AL),
    .PULSE_MASK      (PM)
  ) dut (
    .SIM_CLK    (SIM_CLK),
    .SIM_RST    (SIM_RST),
    .RAW        (RAW),
    .LEVEL      (LEVEL),
    .EDGE       (EDGE),
    .OUT        (OUT),
    .ANY_CHANGE (ANY_CHANGE)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: logical samples per clock; a channel flips once the last D samples
  // seen by the debouncer (two clocks old) all disagree with its stable value.
  logic [3:0] hist[$];
  logic [3:0] m_s;
  logic [3:0] m_edge;
  logic [3:0] m_flip;
  logic [3:0] m_out;
  int         m_last_rise[4];
  int         cyc;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < int'(D) + 2; k++) hist.push_back(4'b0000);
    m_s    = 4'b0000;
    m_edge = 4'b0000;
    m_flip = 4'b0000;
    m_out  = 4'b0000;
    cyc    = 0;
    for (int c = 0; c < 4; c++) m_last_rise[c] = -100;
  endtask

  task automatic model_step(input logic [3:0] raw);
    bit all_differ;
    cyc++;
    hist.push_back(raw ^ AL);
    if (hist.size() > int'(D) + 2) void'(hist.pop_front());
    m_flip = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      all_differ = 1'b1;
      for (int k = 0; k < int'(D); k++) begin
        if (hist[k][c] == m_s[c]) all_differ = 1'b0;
      end
      m_flip[c] = all_differ;
    end
    m_edge = m_flip & ~m_s;
    m_s    = m_s ^ m_flip;
    for (int c = 0; c < 4; c++) begin
      if (m_edge[c]) m_last_rise[c] = cyc;
      m_out[c] = PM[c] ? ((cyc - m_last_rise[c]) < int'(PC)) : m_s[c];
    end
  endtask

  task automatic step(input logic [3:0] raw);
    RAW = raw;
    @(posedge SIM_CLK);
    #1;
    model_step(raw);
    check_eq("LEVEL", 32'(LEVEL), 32'(m_s));
    check_eq("EDGE", 32'(EDGE), 32'(m_edge));
    check_eq("OUT", 32'(OUT), 32'(m_out));
    check_eq("ANY_CHANGE", 32'(ANY_CHANGE), 32'(|m_flip));
  endtask

  // Asserts reset away from the clock edge and checks it acts immediately.
  task automatic do_reset(input logic [3:0] raw);
    RAW = raw;
    SIM_RST = 1'b1;
    #1;
    check_eq("RST_LEVEL", 32'(LEVEL), 32'd0);
    check_eq("RST_EDGE", 32'(EDGE), 32'd0);
    check_eq("RST_OUT", 32'(OUT), 32'd0);
    check_eq("RST_ANY", 32'(ANY_CHANGE), 32'd0);
    repeat (2) @(posedge SIM_CLK);
    #1;
    SIM_RST = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] raw;
    int first;
    int n_e;
    int n_o;
    int n_a;
    int n_l;
    logic [3:0] edge_seen;

    SIM_RST = 1'b1;
    RAW = 4'b0001;
    model_reset();

    // 1: idle after reset
    do_reset(4'b0001);
    n_a = 0;
    for (int s = 0; s < 20; s++) begin
      step(4'b0001);
      if (LEVEL != 0 || EDGE != 0 || OUT != 0 || ANY_CHANGE) n_a++;
    end
    check_eq("T1_IDLE_ACTIVITY", 32'(n_a), 32'd0);

    // 2: press channel 0 (active low)
    first = 0; n_e = 0; n_o = 0; n_a = 0;
    for (int s = 1; s <= 15; s++) begin
      step(4'b0000);
      if (EDGE[0]) begin
        n_e++;
        if (first == 0) first = s;
      end
      if (OUT[0]) n_o++;
      if (ANY_CHANGE) n_a++;
    end
    check_eq("T2_EDGE_LATENCY", 32'(first), 32'd6);
    check_eq("T2_EDGE_COUNT", 32'(n_e), 32'd1);
    check_eq("T2_PULSE_WIDTH", 32'(n_o), 32'd3);
    check_eq("T2_ANY_COUNT", 32'(n_a), 32'd1);

    // 3: short glitch on channel 1, then a real press
    n_l = 0; n_a = 0;
    for (int s = 0; s < 3; s++) begin
      step(4'b0010);
      if (LEVEL[1]) n_l++;
      if (ANY_CHANGE) n_a++;
    end
    for (int s = 0; s < 10; s++) begin
      step(4'b0000);
      if (LEVEL[1]) n_l++;
      if (ANY_CHANGE) n_a++;
    end
    check_eq("T3_GLITCH_LEVEL", 32'(n_l), 32'd0);
    check_eq("T3_GLITCH_STROBES", 32'(n_a), 32'd0);
    first = 0; n_a = 0;
    for (int s = 1; s <= 10; s++) begin
      step(4'b0010);
      if (LEVEL[1] && first == 0) first = s;
      if (ANY_CHANGE) n_a++;
    end
    check_eq("T3_LEVEL_LATENCY", 32'(first), 32'd6);
    check_eq("T3_ANY_COUNT", 32'(n_a), 32'd1);
    check_eq("T3_OUT_FOLLOWS", 32'(OUT[1]), 32'd1);

    // 4: channels 2 and 3 together, then release
    first = 0; n_a = 0; edge_seen = 4'b0000;
    for (int s = 1; s <= 10; s++) begin
      step(4'b1110);
      if (LEVEL[3:2] == 2'b11 && first == 0) begin
        first = s;
        edge_seen = EDGE;
      end
      if (ANY_CHANGE) n_a++;
    end
    check_eq("T4_PAIR_LATENCY", 32'(first), 32'd6);
    check_eq("T4_PAIR_EDGES", 32'(edge_seen[3:2]), 32'd3);
    check_eq("T4_PAIR_ANY", 32'(n_a), 32'd1);
    first = 0; n_a = 0; n_e = 0;
    for (int s = 1; s <= 10; s++) begin
      step(4'b0010);
      if (LEVEL[3:2] == 2'b00 && first == 0) first = s;
      if (EDGE[3:2] != 2'b00) n_e++;
      if (ANY_CHANGE) n_a++;
    end
    check_eq("T4_RELEASE_LATENCY", 32'(first), 32'd6);
    check_eq("T4_RELEASE_EDGES", 32'(n_e), 32'd0);
    check_eq("T4_RELEASE_ANY", 32'(n_a), 32'd1);

    // 5: reset in the middle of a pulse
    for (int s = 0; s < 10; s++) step(4'b0011);
    first = 0;
    for (int s = 1; s <= 12 && first == 0; s++) begin
      step(4'b0010);
      if (EDGE[0]) first = s;
    end
    check_eq("T5_EDGE_LATENCY", 32'(first), 32'd6);
    step(4'b0010);
    check_eq("T5_PULSE_MID", 32'(OUT[0]), 32'd1);
    do_reset(4'b0010);
    first = 0;
    for (int s = 1; s <= 12; s++) begin
      step(4'b0010);
      if (EDGE[0] && first == 0) first = s;
    end
    check_eq("T5_EDGE_AFTER_RST", 32'(first), 32'd6);

    // 6: bouncing press on channel 0
    for (int s = 0; s < 12; s++) step(4'b0011);
    first = 0; n_e = 0;
    for (int s = 1; s <= 16; s++) begin
      raw = (s == 4) ? 4'b0011 : 4'b0010;
      step(raw);
      if (EDGE[0]) begin
        n_e++;
        if (first == 0) first = s;
      end
    end
    check_eq("T6_BOUNCE_EDGES", 32'(n_e), 32'd1);
    check_eq("T6_BOUNCE_LATENCY", 32'(first), 32'd10);

    // Random pin activity with occasional asynchronous resets
    raw = 4'b0010;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset(raw);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      end
      step(raw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
